// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, reset to RST_VAL.
module uart_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with held-valid/ack byte output,
// one-cycle framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev;
  logic fall;

  uart_state_t          state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 deliver, deliver_n;
  logic                 ferr_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 ovr_n;

  uart_sync #(.RST_VAL(UART_IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign fall    = rx_prev & ~rx_s;
  assign rx_busy = (state != IDLE);

  // Receive FSM, bit timer and shift register
  always_comb begin
    state_n   = state;
    timer_n   = (timer != '0) ? timer - 1'b1 : timer;
    idx_n     = idx;
    shreg_n   = shreg;
    deliver_n = 1'b0;
    ferr_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          timer_n = T_HALF;
        end
      end
      START: begin
        if (timer == '0) begin
          if (!rx_s) begin
            state_n = DATA;
            timer_n = T_FULL;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end
      end
      DATA: begin
        if (timer == '0) begin
          // Right-shift in: after DATA_BITS samples the first wire bit sits at bit 0
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          idx_n   = idx + 1'b1;
          timer_n = T_FULL;
          if (idx == LAST_IDX) state_n = STOP;
        end
      end
      STOP: begin
        if (timer == '0) begin
          deliver_n = rx_s;
          ferr_n    = ~rx_s;
          state_n   = IDLE;
          timer_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Consumer-side output registers
  always_comb begin
    data_n  = rx_data;
    valid_n = rx_valid;
    ovr_n   = rx_overrun;
    if (deliver) begin
      if (!rx_valid || rx_ack) begin
        data_n  = shreg;
        valid_n = 1'b1;
        ovr_n   = 1'b0;
      end else begin
        ovr_n   = 1'b1;
      end
    end else if (rx_valid && rx_ack) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev      <= UART_IDLE_LEVEL;
      state        <= IDLE;
      timer        <= '0;
      idx          <= '0;
      shreg        <= '0;
      deliver      <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_prev      <= rx_s;
      state        <= state_n;
      timer        <= timer_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      deliver      <= deliver_n;
      rx_frame_err <= ferr_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_overrun   <= ovr_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner
// sequences and a randomized run against a frame-level consumer model.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic          rx_ack = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_overrun;
  logic          rx_busy;

  int n_vec = 0;
  int n_err = 0;
  int ferr_cyc = 0;
  int busy_cyc = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_frame_err) ferr_cyc <= ferr_cyc + 1;
    if (rx_busy)      busy_cyc <= busy_cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       ack;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one full frame (start, data LSB-first, stop); ack_at pulses rx_ack
  // in the clock that follows edge number ack_at counted from the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at);
    logic [9:0] sh;
    sh = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < CPB; k++) begin
        @(posedge clk);
        #1;
        rx_in  = sh[0];
        rx_ack = ((b * CPB + k) == ack_at);
      end
      sh = sh >> 1;
    end
    rx_ack = 1'b0;
  endtask

  task automatic idle(input int n, input logic lvl);
    repeat (n) begin
      @(posedge clk);
      #1;
      rx_in  = lvl;
      rx_ack = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1;
    rx_in  = 1'b1;
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
  endtask

  initial begin
    int         f0;
    int         b0;
    logic [7:0] d;
    logic       stop;
    logic       do_ack;
    int         gap;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovr;

    vecs[0] = '{8'hA5, 1'b1, 40, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
    vecs[1] = '{8'h3C, 1'b0, 20, 1'b0, 1'b0, 8'hA5, 1'b0, 1};
    vecs[2] = '{8'h81, 1'b1, 4,  1'b1, 1'b1, 8'h81, 1'b0, 0};
    vecs[3] = '{8'h11, 1'b1, 0,  1'b0, 1'b1, 8'h11, 1'b0, 0};
    vecs[4] = '{8'h22, 1'b1, 0,  1'b1, 1'b1, 8'h11, 1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_data", 32'(rx_data), 0);
    chk("reset_ferr", 32'(rx_frame_err), 0);
    chk("reset_ovr", 32'(rx_overrun), 0);
    chk("reset_busy", 32'(rx_busy), 0);
    rst = 1'b0;
    idle(10, 1'b1);

    for (int i = 0; i < 5; i++) begin
      f0 = ferr_cyc;
      send_frame(vecs[i].data, vecs[i].stop, -1);
      idle(vecs[i].gap, 1'b1);
      chk($sformatf("tbl%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("tbl%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      chk($sformatf("tbl%0d_ovr", i), 32'(rx_overrun), 32'(vecs[i].exp_ovr));
      chk($sformatf("tbl%0d_ferr_cycles", i), 32'(ferr_cyc - f0), 32'(vecs[i].exp_ferr));
      chk($sformatf("tbl%0d_busy", i), 32'(rx_busy), 0);
      if (vecs[i].ack) begin
        ack_pulse();
        chk($sformatf("tbl%0d_ack_valid", i), 32'(rx_valid), 0);
        chk($sformatf("tbl%0d_ack_ovr", i), 32'(rx_overrun), 0);
      end
    end

    // Short low glitch: rejected at the mid start-bit sample
    f0 = ferr_cyc;
    b0 = busy_cyc;
    for (int j = 0; j <= 12; j++) begin
      @(posedge clk);
      #1;
      rx_in = (j < 4) ? 1'b0 : 1'b1;
    end
    chk("glitch_busy_idle", 32'(rx_busy), 0);
    chk("glitch_busy_seen", 32'((busy_cyc - b0) > 0), 1);
    chk("glitch_valid", 32'(rx_valid), 0);
    chk("glitch_ferr", 32'(ferr_cyc - f0), 0);
    idle(20, 1'b1);

    // Line held low after a framing error must not start a new frame
    f0 = ferr_cyc;
    send_frame(8'h3C, 1'b0, -1);
    chk("holdlow_ferr", 32'(ferr_cyc - f0), 1);
    b0 = busy_cyc;
    idle(40, 1'b0);
    chk("holdlow_no_busy", 32'(busy_cyc - b0), 0);
    chk("holdlow_valid", 32'(rx_valid), 0);
    idle(10, 1'b1);

    // Ack coincident with delivery of the following frame
    send_frame(8'h5A, 1'b1, -1);
    chk("ackdeliv_first_valid", 32'(rx_valid), 1);
    chk("ackdeliv_first_data", 32'(rx_data), 32'h5A);
    send_frame(8'h55, 1'b1, 155);
    chk("ackdeliv_valid", 32'(rx_valid), 1);
    chk("ackdeliv_data", 32'(rx_data), 32'h55);
    chk("ackdeliv_ovr", 32'(rx_overrun), 0);

    // Reset in the middle of data bit 3 of 0xFF, with a byte still pending
    for (int j = 0; j < 72; j++) begin
      @(posedge clk);
      #1;
      rx_in = (j < CPB) ? 1'b0 : 1'b1;
    end
    chk("midrst_busy_before", 32'(rx_busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(rx_valid), 0);
    chk("midrst_data", 32'(rx_data), 0);
    chk("midrst_ovr", 32'(rx_overrun), 0);
    chk("midrst_ferr", 32'(rx_frame_err), 0);
    chk("midrst_busy", 32'(rx_busy), 0);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10, 1'b1);
    f0 = ferr_cyc;
    send_frame(8'h42, 1'b1, -1);
    chk("postrst_valid", 32'(rx_valid), 1);
    chk("postrst_data", 32'(rx_data), 32'h42);
    chk("postrst_ovr", 32'(rx_overrun), 0);
    chk("postrst_ferr", 32'(ferr_cyc - f0), 0);
    ack_pulse();
    chk("postrst_ack_valid", 32'(rx_valid), 0);

    // Randomized frames against a frame-level consumer model
    m_valid = 1'b0;
    m_data  = 8'h42;
    m_ovr   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d      = 8'($urandom_range(0, 255));
      stop   = ($urandom_range(0, 7) != 0);
      do_ack = ($urandom_range(0, 1) == 1);
      gap    = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(8, 20));
      f0 = ferr_cyc;
      send_frame(d, stop, -1);
      if (stop) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_data  = d;
        end else begin
          m_ovr = 1'b1;
        end
      end
      idle(gap, 1'b1);
      chk($sformatf("rnd%0d_valid", i), 32'(rx_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_data", i), 32'(rx_data), 32'(m_data));
      chk($sformatf("rnd%0d_ovr", i), 32'(rx_overrun), 32'(m_ovr));
      chk($sformatf("rnd%0d_ferr", i), 32'(ferr_cyc - f0), stop ? 32'd0 : 32'd1);
      if (do_ack) begin
        ack_pulse();
        if (m_valid) begin
          m_valid = 1'b0;
          m_ovr   = 1'b0;
        end
        chk($sformatf("rnd%0d_ack_valid", i), 32'(rx_valid), 32'(m_valid));
        chk($sformatf("rnd%0d_ack_ovr", i), 32'(rx_overrun), 32'(m_ovr));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
